fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage.
//
// Issues one instruction-memory request at a time, presents each returned word to decode
// together with its address, and absorbs one word while decode is stalled. A redirect
// (br_taken) flushes the presented and buffered instruction and restarts fetch at the
// word-aligned br_target. When a redirect arrives while a request is still outstanding,
// the unit waits for that response and discards it before fetching from the target.
//
// Parameters:
//   WORD      address / PC width
//   INST_SIZE instruction width
//   RESET_PC  first fetch address after reset
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   imem_req    request valid (high in REQ and DROP)
//   imem_addr   request byte address, stable until imem_ack
//   imem_ack    response for the pending request this cycle
//   imem_rdata  response data, valid with imem_ack
//   stall       decode cannot accept; if_* outputs hold
//   br_taken    redirect pulse
//   br_target   redirect address (low two bits ignored)
//   if_valid    if_inst/if_pc hold a live instruction
//   if_inst     instruction presented to decode
//   if_pc       address of if_inst
module fetch_unit #(
  parameter int unsigned    WORD      = 64,
  parameter int unsigned    INST_SIZE = 32,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INST_SIZE-1:0] imem_rdata,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [WORD-1:0]      br_target,
  output logic                 if_valid,
  output logic [INST_SIZE-1:0] if_inst,
  output logic [WORD-1:0]      if_pc
);

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StBuf  = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e                 state_q;
  logic [WORD-1:0]        pc_q;        // address of the pending (or next) request
  logic [WORD-1:0]        tgt_q;       // redirect target held while draining in DROP
  logic [INST_SIZE-1:0]   buf_inst_q;
  logic [WORD-1:0]        buf_pc_q;

  logic [WORD-1:0] br_aligned;
  logic [WORD-1:0] pc_plus4;

  assign br_aligned = {br_target[WORD-1:2], 2'b00};
  assign pc_plus4   = pc_q + WORD'(4);  // wraps modulo 2^WORD

  // Gated with rst so no request is visible while reset is held.
  assign imem_req  = (state_q != StBuf) && !rst;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      buf_inst_q <= '0;
      buf_pc_q   <= '0;
      if_valid   <= 1'b0;
      if_inst    <= '0;
      if_pc      <= '0;
    end else begin
      unique case (state_q)
        StReq: begin
          if (br_taken) begin
            if_valid <= 1'b0;
            if (imem_ack) begin
              // Response consumed by this edge; drop it and go straight to the target.
              pc_q <= br_aligned;
            end else begin
              tgt_q   <= br_aligned;
              state_q <= StDrop;
            end
          end else if (imem_ack) begin
            pc_q <= pc_plus4;
            if (!if_valid || !stall) begin
              if_valid <= 1'b1;
              if_inst  <= imem_rdata;
              if_pc    <= pc_q;
            end else begin
              buf_inst_q <= imem_rdata;
              buf_pc_q   <= pc_q;
              state_q    <= StBuf;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end

        StBuf: begin
          if (br_taken) begin
            if_valid <= 1'b0;
            pc_q     <= br_aligned;
            state_q  <= StReq;
          end else if (!stall) begin
            if_valid <= 1'b1;
            if_inst  <= buf_inst_q;
            if_pc    <= buf_pc_q;
            state_q  <= StReq;
          end
        end

        StDrop: begin
          if (imem_ack) begin
            // The stale response has arrived; a redirect in the same cycle wins over the
            // held target, otherwise waiting for a second ack would deadlock.
            pc_q    <= br_taken ? br_aligned : tgt_q;
            state_q <= StReq;
          end else if (br_taken) begin
            tgt_q <= br_aligned;
          end
          if (br_taken || !stall) begin
            if_valid <= 1'b0;
          end
        end

        default: state_q <= StReq;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed fetch/stall/redirect scenarios followed by randomized
// stall, redirect and memory latency, checked against an in-order program stream model.
module tb_fetch_unit;

  localparam int unsigned WORD      = 64;
  localparam int unsigned INST_SIZE = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 imem_req;
  logic [WORD-1:0]      imem_addr;
  logic                 imem_ack = 1'b0;
  logic [INST_SIZE-1:0] imem_rdata = '0;
  logic                 stall = 1'b0;
  logic                 br_taken = 1'b0;
  logic [WORD-1:0]      br_target = '0;
  logic                 if_valid;
  logic [INST_SIZE-1:0] if_inst;
  logic [WORD-1:0]      if_pc;

  // Second instance exercising the PC wrap from the top of the address space.
  logic                 req_w;
  logic [WORD-1:0]      addr_w;
  logic                 ack_w = 1'b1;
  logic [INST_SIZE-1:0] rdata_w = 32'h1400_0040;
  logic                 zero_w = 1'b0;
  logic [WORD-1:0]      tgt_w = '0;
  logic                 v_w;
  logic [INST_SIZE-1:0] inst_w;
  logic [WORD-1:0]      pc_w;

  always #5 clk = ~clk;

  fetch_unit #(.WORD(WORD), .INST_SIZE(INST_SIZE), .RESET_PC(64'h0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc)
  );

  fetch_unit #(.WORD(WORD), .INST_SIZE(INST_SIZE), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (req_w),
    .imem_addr  (addr_w),
    .imem_ack   (ack_w),
    .imem_rdata (rdata_w),
    .stall      (zero_w),
    .br_taken   (zero_w),
    .br_target  (tgt_w),
    .if_valid   (v_w),
    .if_inst    (inst_w),
    .if_pc      (pc_w)
  );

  int vectors     = 0;
  int miscompares = 0;
  int checks      = 0;
  int consumed    = 0;

  // Expected program-order stream of addresses decode should consume.
  logic [WORD-1:0] exp_q[$];
  logic [WORD-1:0] exp_pc;

  logic            prev_pending = 1'b0;
  logic [WORD-1:0] prev_addr    = '0;

  function automatic logic [INST_SIZE-1:0] mem(input logic [WORD-1:0] a);
    case (a)
      64'h0:   return 32'hF844_02C9;
      64'h4:   return 32'h8B09_026A;
      64'h8:   return 32'hCB0A_028B;
      64'hC:   return 32'hF806_02CB;
      64'h10:  return 32'hB4FF_FF6B;
      default: return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  task automatic check64(input string name, input logic [WORD-1:0] act,
                         input logic [WORD-1:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check64(name, {63'h0, act}, {63'h0, exp});
  endtask

  task automatic check32(input string name, input logic [INST_SIZE-1:0] act,
                         input logic [INST_SIZE-1:0] exp);
    check64(name, {32'h0, act}, {32'h0, exp});
  endtask

  // Apply one cycle of stimulus, update the stream model, and step past the next edge.
  task automatic drive(input logic s, input logic b, input logic [WORD-1:0] t,
                       input logic a);
    stall      = s;
    br_taken   = b;
    br_target  = t;
    imem_ack   = a && imem_req;
    imem_rdata = imem_ack ? mem(imem_addr) : $urandom;
    if (b) begin
      exp_q.delete();
      exp_pc = {t[WORD-1:2], 2'b00};
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 64'd4;
    end
    vectors++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: protocol stability and in-order delivery of consumed instructions.
  always @(negedge clk) begin
    if (rst) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) check64("addr_hold", imem_addr, prev_addr);
      prev_pending = imem_req && !imem_ack;
      prev_addr    = imem_addr;
      if (if_valid && !stall && !br_taken) begin
        if (exp_q.size() == 0) begin
          checks++;
          miscompares++;
          $display("FAIL stream: got pc %h but no instruction expected", if_pc);
        end else begin
          logic [WORD-1:0] e;
          e = exp_q.pop_front();
          check64("stream_pc", if_pc, e);
          check32("stream_inst", if_inst, mem(e));
          consumed++;
        end
      end
    end
  end

  initial begin
    logic [WORD-1:0] t;
    exp_q.delete();
    exp_pc = 64'h0;
    #2;
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", if_valid, 1'b0);
    check32("rst_inst", if_inst, 32'h0);
    check64("rst_pc", if_pc, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check1("first_req", imem_req, 1'b1);
    check64("first_addr", imem_addr, 64'h0);
    check64("wrap_first_addr", addr_w, 64'hFFFF_FFFF_FFFF_FFFC);

    // Back-to-back acks: one instruction per cycle.
    drive(1'b0, 1'b0, '0, 1'b1);
    check1("seq0_valid", if_valid, 1'b1);
    check64("seq0_pc", if_pc, 64'h0);
    check32("seq0_inst", if_inst, 32'hF844_02C9);
    check1("wrap_valid", v_w, 1'b1);
    check64("wrap_pc", pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
    check32("wrap_inst", inst_w, 32'h1400_0040);
    check64("wrap_next_addr", addr_w, 64'h0);
    drive(1'b0, 1'b0, '0, 1'b1);
    check1("seq1_valid", if_valid, 1'b1);
    check64("seq1_pc", if_pc, 64'h4);
    check32("seq1_inst", if_inst, 32'h8B09_026A);
    drive(1'b0, 1'b0, '0, 1'b1);
    check1("seq2_valid", if_valid, 1'b1);
    check64("seq2_pc", if_pc, 64'h8);
    check32("seq2_inst", if_inst, 32'hCB0A_028B);
    check64("seq2_addr", imem_addr, 64'hC);

    // Delayed ack: address held, no live instruction in between.
    repeat (3) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      check64("wait_addr", imem_addr, 64'hC);
      check1("wait_valid", if_valid, 1'b0);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    check64("late_pc", if_pc, 64'hC);
    check32("late_inst", if_inst, 32'hF806_02CB);

    // Stall with a word arriving: it is buffered and requests stop.
    drive(1'b1, 1'b0, '0, 1'b1);
    check64("stall_pc", if_pc, 64'hC);
    check1("stall_req", imem_req, 1'b0);
    repeat (3) begin
      drive(1'b1, 1'b0, '0, 1'b1);
      check32("stall_inst", if_inst, 32'hF806_02CB);
      check1("stall_valid", if_valid, 1'b1);
      check1("buf_req", imem_req, 1'b0);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    check32("unstall_inst", if_inst, 32'hB4FF_FF6B);
    check64("unstall_pc", if_pc, 64'h10);
    check1("resume_req", imem_req, 1'b1);
    check64("resume_addr", imem_addr, 64'h14);

    // Redirect while a request is outstanding: old response dropped.
    drive(1'b0, 1'b1, 64'h103, 1'b0);
    check1("drop_valid", if_valid, 1'b0);
    check64("drop_addr", imem_addr, 64'h14);
    drive(1'b0, 1'b0, '0, 1'b1);
    check1("drop_ack_valid", if_valid, 1'b0);
    check64("redir_addr", imem_addr, 64'h100);
    drive(1'b0, 1'b0, '0, 1'b1);
    check1("redir_valid", if_valid, 1'b1);
    check64("redir_pc", if_pc, 64'h100);

    // Redirect coincident with ack while stalled.
    drive(1'b1, 1'b1, 64'h200, 1'b1);
    check1("br_ack_valid", if_valid, 1'b0);
    check64("br_ack_addr", imem_addr, 64'h200);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      t = {52'h0, 12'($urandom)};
      if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, t,
            $urandom_range(0, 2) != 0);
    end
    drive(1'b0, 1'b0, '0, 1'b0);

    checks++;
    if (consumed < 200) begin
      miscompares++;
      $display("FAIL delivered: got %0d instructions required at least 200", consumed);
    end

    // Asynchronous reset mid-operation.
    rst = 1'b1;
    #1;
    check1("arst_req", imem_req, 1'b0);
    check1("arst_valid", if_valid, 1'b0);
    check64("arst_addr", imem_addr, 64'h0);
    check64("arst_pc", if_pc, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
